// File: rtl/decrypt_pkg.sv
// decrypt_pkg: constants, FSM state type and LFSR step function shared by
// the message-decryption engine (top_level) and its data memory.
package decrypt_pkg;

  // Message geometry.
  localparam int MSG_LEN  = 64;  // ciphertext / plaintext length in bytes
  localparam int PAD_MIN  = 10;  // guaranteed leading space pads, used as seed window
  localparam int NUM_TAPS = 9;   // entries in the tap candidate ROM

  localparam logic [7:0] CT_BASE     = 8'd64;  // address of ciphertext byte 0
  localparam logic [7:0] SPACE       = 8'h20;  // pad / fill character
  localparam logic [6:0] TAP_DEFAULT = 7'h60;  // fallback tap when no candidate matches

  // Tap candidates in search order; the first full match wins.
  localparam logic [6:0] TAP_ROM [NUM_TAPS] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SEARCH,
    ST_SCAN,
    ST_COPY,
    ST_FILL,
    ST_DONE
  } state_t;

  // One LFSR step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [6:0] lfsr_next(input logic [6:0] cur, input logic [6:0] tap);
    return {cur[5:0], ^(cur & tap)};
  endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem: 256x8 data memory with a combinational read port and a
// synchronous write port (one write per cycle). Array name Core is kept so
// external code can reach it hierarchically as DM.Core[addr].
module data_mem (
  input  logic       clk,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] Core [0:255];

  // Synchronous write port.
  // NOTE: memory contents have no reset; init leaves data untouched and a
  // reset loop over 256 entries would not map onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      Core[i_waddr] <= i_wdata;
    end
  end

  // Combinational read port.
  assign o_rdata = Core[i_raddr];

endmodule

// File: rtl/top_level.sv
// top_level: hardwired message-decryption engine. Recovers the LFSR seed and
// tap from the space pads of the ciphertext at Core[64..127], decrypts,
// strips leading spaces and writes the plaintext to Core[0..63].
// Optional feature macro PARITY_FLAG_EN: when defined, a parity error sets
// the output MSB and stops space stripping; when undefined, parity is ignored.
import decrypt_pkg::*;

module top_level (
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);

  // FSM and datapath state.
  state_t     r_state, w_state_next;
  logic [6:0] r_idx,   w_idx_next;    // byte index within the current phase
  logic [3:0] r_cand,  w_cand_next;   // tap candidate under test
  logic [6:0] r_lfsr,  w_lfsr_next;   // running keystream value
  logic [6:0] r_tap,   w_tap_next;    // selected tap pattern
  logic [6:0] r_k,     w_k_next;      // leading bytes to strip (0..64)

  // Keystream samples e[i] = c[i][6:0] ^ space taken from the pad window.
  logic [6:0] r_e [PAD_MIN];
  logic       w_e_we;

  // Memory port signals.
  logic       w_mem_we;
  logic [7:0] w_mem_waddr;
  logic [7:0] w_mem_wdata;
  logic [7:0] w_mem_raddr;
  logic [7:0] w_mem_rdata;

  // Decode of the ciphertext byte currently addressed.
  logic [6:0] w_seed;
  logic [6:0] w_plain;
  logic       w_err;
  logic       w_stop;
  logic [6:0] w_search_step;
  logic [6:0] w_run_step;

  data_mem DM (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_mem_rdata)
  );

  // Every phase that reads walks the ciphertext by r_idx.
  assign w_mem_raddr = CT_BASE + {1'b0, r_idx};

  assign w_seed        = r_e[0];
  assign w_plain       = w_mem_rdata[6:0] ^ r_lfsr;
  assign w_search_step = lfsr_next(r_lfsr, TAP_ROM[r_cand]);
  assign w_run_step    = lfsr_next(r_lfsr, r_tap);

`ifdef PARITY_FLAG_EN
  // Even parity over all eight bits; any odd byte is corrupted.
  assign w_err = ^w_mem_rdata;
`else
  // Parity is ignored; the MSB of the ciphertext carries no information.
  logic w_unused_msb;
  assign w_unused_msb = w_mem_rdata[7];
  assign w_err        = 1'b0;
`endif

  // A corrupted byte or any non-space ends the leading-space run.
  assign w_stop = w_err | (w_plain != SPACE[6:0]);

  assign ack = (r_state == ST_DONE);

  // State and datapath registers; init returns to IDLE with ack low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (init) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cand  <= '0;
      r_lfsr  <= '0;
      r_tap   <= TAP_DEFAULT;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cand  <= w_cand_next;
      r_lfsr  <= w_lfsr_next;
      r_tap   <= w_tap_next;
      r_k     <= w_k_next;
    end
  end

  // Capture keystream samples while reading the pad window.
  always_ff @(posedge clk) begin
    if (w_e_we) begin
      r_e[r_idx[3:0]] <= w_mem_rdata[6:0] ^ SPACE[6:0];
    end
  end

  // Next-state, datapath updates and memory write control.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cand_next  = r_cand;
    w_lfsr_next  = r_lfsr;
    w_tap_next   = r_tap;
    w_k_next     = r_k;
    w_e_we       = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = '0;
    w_mem_wdata  = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (!req) begin
          w_state_next = ST_SEED;
          w_idx_next   = '0;
        end
      end

      // Read the pad window c[0..PAD_MIN-1] into the keystream samples.
      ST_SEED: begin
        w_e_we = 1'b1;
        if (r_idx == 7'(PAD_MIN - 1)) begin
          w_state_next = ST_SEARCH;
          w_idx_next   = 7'd1;
          w_cand_next  = '0;
          w_lfsr_next  = w_seed;
        end else begin
          w_idx_next = r_idx + 7'd1;
        end
      end

      // Step each candidate from the seed and compare against e[1..9];
      // a mismatch abandons the candidate at once.
      ST_SEARCH: begin
        if (w_search_step != r_e[r_idx[3:0]]) begin
          if (r_cand == 4'(NUM_TAPS - 1)) begin
            w_state_next = ST_SCAN;
            w_tap_next   = TAP_DEFAULT;
            w_idx_next   = '0;
            w_lfsr_next  = w_seed;
          end else begin
            w_cand_next = r_cand + 4'd1;
            w_idx_next  = 7'd1;
            w_lfsr_next = w_seed;
          end
        end else if (r_idx == 7'(PAD_MIN - 1)) begin
          w_state_next = ST_SCAN;
          w_tap_next   = TAP_ROM[r_cand];
          w_idx_next   = '0;
          w_lfsr_next  = w_seed;
        end else begin
          w_idx_next  = r_idx + 7'd1;
          w_lfsr_next = w_search_step;
        end
      end

      // Find the first byte that is not a clean space; none means k = 64.
      ST_SCAN: begin
        if (w_stop || (r_idx == 7'(MSG_LEN - 1))) begin
          w_state_next = ST_COPY;
          w_k_next     = w_stop ? r_idx : 7'(MSG_LEN);
          w_idx_next   = '0;
          w_lfsr_next  = w_seed;
        end else begin
          w_idx_next  = r_idx + 7'd1;
          w_lfsr_next = w_run_step;
        end
      end

      // Re-walk from the seed; bytes at or past k shift down by k.
      ST_COPY: begin
        if (r_idx >= r_k) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = {1'b0, r_idx - r_k};
          w_mem_wdata = {w_err, w_plain};
        end
        w_lfsr_next = w_run_step;
        if (r_idx == 7'(MSG_LEN - 1)) begin
          w_state_next = ST_FILL;
          w_idx_next   = 7'(MSG_LEN) - r_k;
        end else begin
          w_idx_next = r_idx + 7'd1;
        end
      end

      // Pad the tail Core[64-k..63] with spaces; k = 0 writes nothing.
      ST_FILL: begin
        if (r_idx == 7'(MSG_LEN)) begin
          w_state_next = ST_DONE;
        end else begin
          w_mem_we    = 1'b1;
          w_mem_waddr = {1'b0, r_idx};
          w_mem_wdata = SPACE;
          w_idx_next  = r_idx + 7'd1;
        end
      end

      // Hold with ack high until the next init.
      ST_DONE: begin
        w_state_next = ST_DONE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_top_level.sv
// tb_top_level: randomized and directed bench for top_level. Ciphertext is
// built by an encoder, expected plaintext comes from a behavioural model of
// the decryption rules and is queued for a monitor that compares Core[0..63]
// whenever ack rises.
module tb_top_level;

  logic clk = 1'b0;
  logic init;
  logic req;
  logic ack;

  top_level dut (
    .clk  (clk),
    .init (init),
    .req  (req),
    .ack  (ack)
  );

  always #5 clk = ~clk;

`ifdef PARITY_FLAG_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [6:0] CAND [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];
  string      cur_tag;

  logic [6:0] pt        [64];
  logic [7:0] ct        [64];
  logic [7:0] exp_out   [64];
  logic [7:0] upper_ref [128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] lfsr(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // Plaintext: pad spaces, then the message, then trailing spaces.
  task automatic set_pt_msg(input int pad, input string msg);
    byte b;
    for (int i = 0; i < 64; i++) begin
      if (i >= pad && (i - pad) < msg.len()) begin
        b     = msg.getc(i - pad);
        pt[i] = b[6:0];
      end else begin
        pt[i] = 7'h20;
      end
    end
  endtask

  task automatic set_pt_random(input int pad);
    int len;
    len = $urandom_range(0, 64 - pad);
    for (int i = 0; i < 64; i++) begin
      if (i < pad || (i - pad) >= len) pt[i] = 7'h20;
      else if (i == pad)               pt[i] = 7'($urandom_range(33, 126));
      else                             pt[i] = 7'($urandom_range(32, 126));
    end
  endtask

  // Encrypt with the given tap/seed and attach even parity in the MSB.
  task automatic encode(input logic [6:0] tap, input logic [6:0] seed);
    logic [6:0] s;
    logic [6:0] c7;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      c7    = pt[i] ^ s;
      ct[i] = {^c7, c7};
      s     = lfsr(s, tap);
    end
  endtask

  // Reference: recover tap/seed, decrypt, strip, flag, pad.
  task automatic model_run();
    logic [6:0] e [10];
    logic [6:0] p [64];
    bit         er [64];
    logic [6:0] tap;
    logic [6:0] s;
    bit         found;
    bit         ok;
    int         k;
    for (int i = 0; i < 10; i++) e[i] = ct[i][6:0] ^ 7'h20;
    tap   = 7'h60;
    found = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (!found) begin
        s  = e[0];
        ok = 1'b1;
        for (int j = 1; j < 10; j++) begin
          s = lfsr(s, CAND[c]);
          if (s != e[j]) ok = 1'b0;
        end
        if (ok) begin
          tap   = CAND[c];
          found = 1'b1;
        end
      end
    end
    s = e[0];
    k = 64;
    for (int i = 0; i < 64; i++) begin
      p[i]  = ct[i][6:0] ^ s;
      er[i] = PAR_EN && (^ct[i]);
      if (k == 64 && (er[i] || p[i] != 7'h20)) k = i;
      s = lfsr(s, tap);
    end
    for (int i = 0; i < 64; i++) begin
      if (i + k < 64) exp_out[i] = {er[i + k], p[i + k]};
      else            exp_out[i] = 8'h20;
    end
  endtask

  // Monitor: on every completed run, compare Core[0..63] to the queue.
  always @(posedge ack) begin
    @(negedge clk);
    for (int a = 0; a < 64; a++) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s unexpected_output: ack rose with no expected data queued", cur_tag);
        break;
      end
      check($sformatf("%s byte%0d", cur_tag, a), {24'd0, dut.DM.Core[a]}, {24'd0, exp_q.pop_front()});
    end
  end

  // Init pulse with req held, preload memory, optionally queue expectations, start.
  task automatic start_run(input bit push);
    @(negedge clk);
    req  = 1'b1;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check({cur_tag, " ack_low_after_init"}, {31'd0, ack}, 32'd0);
    for (int a = 0; a < 64; a++) begin
      dut.DM.Core[64 + a] <= ct[a];
      dut.DM.Core[a]      <= 8'hEE;
    end
    repeat (3) @(negedge clk);
    check({cur_tag, " ack_low_while_req_high"}, {31'd0, ack}, 32'd0);
    if (push) begin
      for (int a = 0; a < 64; a++) exp_q.push_back(exp_out[a]);
    end
    req = 1'b0;
  endtask

  task automatic run_case(input string tag);
    bit got;
    cur_tag = tag;
    model_run();
    start_run(1'b1);
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, " ack_within_400"}, {31'd0, got}, 32'd1);
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(posedge clk);
    check({tag, " scoreboard_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
    // ack must hold while req toggles in DONE.
    repeat (4) begin
      @(negedge clk);
      req = ~req;
    end
    @(negedge clk);
    check({tag, " ack_sticky"}, {31'd0, ack}, 32'd1);
    req = 1'b1;
  endtask

  localparam string WATSON = "Mr. Watson, come here. I want to see you.";
  localparam string WISDOM = " Knowledge comes, but wisdom lingers.";

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init = 1'b1;
    req  = 1'b1;
    repeat (3) @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check("reset ack", {31'd0, ack}, 32'd0);

    // Upper half of memory must never be written.
    for (int a = 0; a < 128; a++) begin
      upper_ref[a] = 8'($urandom);
      dut.DM.Core[128 + a] <= upper_ref[a];
    end

    set_pt_msg(10, WATSON);
    encode(7'h60, 7'h01);
    run_case("watson_tap60");

    set_pt_msg(15, WATSON);
    encode(7'h7B, 7'h5A);
    run_case("watson_tap7B");

    set_pt_msg(12, WISDOM);
    encode(7'h6A, 7'h33);
    run_case("wisdom_pad12");
    check("wisdom core0", {24'd0, dut.DM.Core[0]}, 32'h4B);

    set_pt_msg(10, WATSON);
    encode(7'h48, 7'h2C);
    ct[30] = ct[30] ^ 8'h04;
    run_case("watson_flip30");
    check("flip core20 msb", {31'd0, dut.DM.Core[20][7]}, {31'd0, PAR_EN});

    set_pt_msg(64, "");
    encode(7'h5C, 7'h11);
    run_case("all_spaces");
    check("all_spaces core63", {24'd0, dut.DM.Core[63]}, 32'h20);

    // Abort mid-run: engine must stay idle with ack low while req is held.
    set_pt_msg(11, WATSON);
    encode(7'h72, 7'h45);
    cur_tag = "abort";
    start_run(1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    req  = 1'b1;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("abort ack_low", {31'd0, ack}, 32'd0);
    repeat (400) @(negedge clk);
    check("abort stays_idle", {31'd0, ack}, 32'd0);
    run_case("abort_rerun");

    // Randomized legal messages, some with a flipped bit.
    for (int n = 0; n < 8; n++) begin
      int pad;
      pad = $urandom_range(10, 30);
      set_pt_random(pad);
      encode(CAND[$urandom_range(0, 8)], 7'($urandom_range(1, 127)));
      if ($urandom_range(0, 1) == 1) begin
        int idx;
        idx     = $urandom_range(10, 63);
        ct[idx] = ct[idx] ^ (8'd1 << $urandom_range(0, 7));
      end
      run_case($sformatf("rand%0d", n));
    end

    // Raw random ciphertext: tap fallback and k = 0 territory.
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 64; i++) ct[i] = 8'($urandom);
      ct[0] = {ct[0][7], 7'h55};
      run_case($sformatf("raw%0d", n));
    end

    for (int a = 0; a < 128; a++) begin
      check($sformatf("upper core%0d", 128 + a), {24'd0, dut.DM.Core[128 + a]}, {24'd0, upper_ref[a]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
